prog_encoder: RTL and testbench

PROG_ENCODER -- requirements
Module: prog_encoder

---
 rtl/isa_pkg.sv | 31 +++
 rtl/inst_check.sv | 12 +
 rtl/prog_encoder.sv | 81 ++++++++
 tb/tb_prog_encoder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// isa_pkg: opcode, condition, field-position, error-code and FSM-state definitions shared by encoder and decoder
package isa_pkg;
  localparam logic [5:0] OPC_ADD  = 6'h00;
  localparam logic [5:0] OPC_SUB  = 6'h01;
  localparam logic [5:0] OPC_AND  = 6'h02;
  localparam logic [5:0] OPC_OR   = 6'h03;
  localparam logic [5:0] OPC_XOR  = 6'h04;
  localparam logic [5:0] OPC_NOT  = 6'h05;
  localparam logic [5:0] OPC_SHL  = 6'h06;
  localparam logic [5:0] OPC_SHR  = 6'h07;
  localparam logic [5:0] OPC_LD   = 6'h08;
  localparam logic [5:0] OPC_ST   = 6'h09;
  localparam logic [5:0] OPC_LDI  = 6'h0A;
  localparam logic [5:0] OPC_MOV  = 6'h0B;
  localparam logic [5:0] OPC_CMP  = 6'h0C;
  localparam logic [5:0] OPC_CTRL = 6'h0D;
  localparam logic [4:0] RD_JMP = 5'd0;
  localparam logic [4:0] RD_BEQ = 5'd1;
  localparam logic [4:0] RD_BLT = 5'd2;
  localparam logic [4:0] RD_BGT = 5'd3;
  localparam int OPC_LSB = 26;
  localparam int RA_LSB  = 21;
  localparam int RB_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int IMD_LSB = 0;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OPC  = 2'd1;
  localparam logic [1:0] ERR_COND = 2'd2;
  localparam logic [1:0] ERR_OVF  = 2'd3;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE, S_ERR} state_t;
endpackage

// File: rtl/inst_check.sv
// inst_check: flags illegal opcodes and illegal control conditions (in: opc, rd; out: legal, err_code)
module inst_check
  import isa_pkg::*;
(
  input  logic [5:0] opc,
  input  logic [4:0] rd,
  output logic       legal,
  output logic [1:0] err_code
);
  assign err_code = opc > OPC_CTRL ? ERR_OPC : (opc == OPC_CTRL && rd > RD_BGT) ? ERR_COND : ERR_NONE;
  assign legal = err_code == ERR_NONE;
endmodule

// File: rtl/prog_encoder.sv
// prog_encoder: streams instruction fields into encoded words written to instruction memory (start/base_addr session ctrl, in_* field handshake, mem_* write port, busy/done/err_code/count status)
module prog_encoder
  import isa_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int MAX_WORDS = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] base_addr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      in_opc,
  input  logic [4:0]      in_ra,
  input  logic [4:0]      in_rb,
  input  logic [4:0]      in_rd,
  input  logic [10:0]     in_imd,
  input  logic            in_last,
  output logic            mem_we,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            busy,
  output logic            done,
  output logic [1:0]      err_code,
  output logic [15:0]     count
);
  state_t state;
  logic [XLEN-1:0] base;
  logic legal, ovf, bad, accept, wr_done;
  logic [1:0] chk_err;
  inst_check u_chk (.opc(in_opc), .rd(in_rd), .legal(legal), .err_code(chk_err));
  assign in_ready = state == S_LOAD && (!mem_we || mem_ready);
  assign accept = in_valid && in_ready;
  assign wr_done = mem_we && mem_ready;
  assign ovf = 32'(count) + 32'(mem_we) >= 32'(MAX_WORDS);
  assign bad = !legal || ovf;
  assign busy = state == S_LOAD || state == S_FLUSH;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      base <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      done <= 1'b0;
      err_code <= ERR_NONE;
      count <= '0;
    end else begin
      done <= 1'b0;
      if (wr_done) begin
        count <= count + 16'd1;
        mem_we <= 1'b0;
      end
      // a completion in the same edge shifts the new word one address further
      if (accept && !bad) begin
        mem_we <= 1'b1;
        mem_addr <= base + XLEN'(count) + XLEN'(wr_done);
        mem_wdata <= XLEN'({in_opc, in_ra, in_rb, in_rd, in_imd});
      end
      case (state)
        S_IDLE, S_ERR: if (start) begin
          state <= S_LOAD;
          base <= base_addr;
          count <= '0;
          err_code <= ERR_NONE;
        end
        S_LOAD: if (accept) begin
          state <= bad ? S_ERR : in_last ? S_FLUSH : S_LOAD;
          if (bad) err_code <= !legal ? chk_err : ERR_OVF;
        end
        S_FLUSH: if (wr_done) begin
          state <= S_DONE;
          done <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_encoder.sv
// tb_prog_encoder: randomized and directed self-checking bench for prog_encoder
module tb_prog_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [31:0] base_addr = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [5:0] in_opc = '0;
  logic [4:0] in_ra = '0;
  logic [4:0] in_rb = '0;
  logic [4:0] in_rd = '0;
  logic [10:0] in_imd = '0;
  logic in_last = 1'b0;
  logic mem_we;
  logic mem_ready = 1'b1;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic busy;
  logic done;
  logic [1:0] err_code;
  logic [15:0] count;
  int checks = 0;
  int errors = 0;
  logic [63:0] obs[$];
  logic [63:0] exp_q[$];
  prog_encoder #(.XLEN(32), .MAX_WORDS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_opc(in_opc), .in_ra(in_ra),
    .in_rb(in_rb), .in_rd(in_rd), .in_imd(in_imd), .in_last(in_last),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err_code(err_code), .count(count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (!rst && mem_we && mem_ready) obs.push_back({mem_addr, mem_wdata});
  function automatic logic [31:0] enc(input int unsigned o, a, b, d, m);
    return 32'(o * 67108864 + a * 2097152 + b * 65536 + d * 2048 + m);
  endfunction
  task automatic start_session(input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    in_valid = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic drive_word(input int o, a, b, d, m, input bit l, input bit rnd, output bit acc);
    acc = 1'b0;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_opc = 6'(o);
      in_ra = 5'(a);
      in_rb = 5'(b);
      in_rd = 5'(d);
      in_imd = 11'(m);
      in_last = l;
      mem_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1 acc = in_ready;
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout: in_ready got 0 for 200 cycles, required 1 (opc=%0d)", o);
    end
  endtask
  task automatic wait_done(input bit rnd);
    bit got = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      mem_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1 got = done;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout: done got 0 for 200 cycles, required 1");
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, mem_we, busy, done, err_code, count, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset: in_ready=%b mem_we=%b busy=%b done=%b err=%0d count=%0d addr=%h data=%h, required all 0",
               in_ready, mem_we, busy, done, err_code, count, mem_addr, mem_wdata);
    end
    rst = 1'b0;
  endtask
  task automatic test_basic;
    bit acc;
    obs.delete();
    start_session(32'h100);
    drive_word(0, 1, 2, 3, 5, 1'b1, 1'b0, acc);
    @(negedge clk);
    checks++;
    if ({mem_we, busy, mem_addr, mem_wdata} !== {2'b11, 32'h100, 32'h00221805}) begin
      errors++;
      $display("FAIL basic_write: we=%b busy=%b addr=%h data=%h, required we=1 busy=1 addr=00000100 data=00221805",
               mem_we, busy, mem_addr, mem_wdata);
    end
    @(negedge clk);
    checks++;
    if ({done, count} !== {1'b1, 16'd1}) begin
      errors++;
      $display("FAIL basic_done: done=%b count=%0d, required done=1 count=1", done, count);
    end
    @(negedge clk);
    checks++;
    if ({done, busy, count} !== {2'b00, 16'd1}) begin
      errors++;
      $display("FAIL basic_after: done=%b busy=%b count=%0d, required 0 0 1", done, busy, count);
    end
  endtask
  task automatic test_random_sessions;
    bit acc;
    logic [31:0] b;
    int n, o, d;
    for (int s = 0; s < 20; s++) begin
      b = $urandom;
      n = $urandom_range(1, 4);
      obs.delete();
      exp_q.delete();
      start_session(b);
      for (int i = 0; i < n; i++) begin
        o = $urandom_range(0, 13);
        d = o == 13 ? $urandom_range(0, 3) : $urandom_range(0, 31);
        begin
          int a = $urandom_range(0, 31);
          int r = $urandom_range(0, 31);
          int m = $urandom_range(0, 2047);
          exp_q.push_back({b + 32'(i), enc(o, a, r, d, m)});
          repeat ($urandom_range(0, 2)) @(negedge clk);
          drive_word(o, a, r, d, m, i == n - 1, 1'b1, acc);
        end
      end
      wait_done(1'b1);
      checks++;
      if (count !== 16'(n)) begin
        errors++;
        $display("FAIL rand_count: session %0d count=%0d, required %0d", s, count, n);
      end
      checks++;
      if (obs.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand_nwrites: session %0d writes=%0d, required %0d", s, obs.size(), exp_q.size());
      end else
        for (int i = 0; i < n; i++) begin
          checks++;
          if (obs[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rand_write: session %0d word %0d got addr/data %h, required %h", s, i, obs[i], exp_q[i]);
          end
        end
    end
  endtask
  task automatic test_stream;
    bit acc;
    logic [31:0] b = $urandom;
    obs.delete();
    start_session(b);
    drive_word(13, 0, 0, 0, 'h123, 1'b0, 1'b1, acc);
    @(negedge clk);
    start = 1'b1;
    base_addr = ~b;
    @(posedge clk);
    #1 start = 1'b0;
    drive_word(13, 0, 0, 1, 'h10, 1'b1, 1'b1, acc);
    wait_done(1'b1);
    checks++;
    if (obs.size() != 2) begin
      errors++;
      $display("FAIL stream_nwrites: writes=%0d, required 2", obs.size());
    end else begin
      checks++;
      if (obs[0] !== {b, enc(13, 0, 0, 0, 'h123)}) begin
        errors++;
        $display("FAIL stream_jmp: got %h, required %h", obs[0], {b, enc(13, 0, 0, 0, 'h123)});
      end
      checks++;
      if (obs[1] !== {b + 32'd1, 32'h34000810}) begin
        errors++;
        $display("FAIL stream_beq: got %h, required %h", obs[1], {b + 32'd1, 32'h34000810});
      end
    end
  endtask
  task automatic test_illegal(input int o, input int d, input logic [1:0] code);
    bit acc;
    obs.delete();
    start_session(32'h40);
    drive_word(1, 1, 1, 1, 1, 1'b0, 1'b0, acc);
    drive_word(o, 2, 2, d, 2, 1'b0, 1'b0, acc);
    @(negedge clk);
    in_valid = 1'b1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({err_code, in_ready, busy} !== {code, 2'b00}) begin
      errors++;
      $display("FAIL illegal_state: err=%0d in_ready=%b busy=%b, required err=%0d in_ready=0 busy=0", err_code, in_ready, busy, code);
    end
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (obs.size() != 1 || obs[0] !== {32'h40, enc(1, 1, 1, 1, 1)} || count !== 16'd1) begin
      errors++;
      $display("FAIL illegal_writes: writes=%0d count=%0d, required 1 legal word at 00000040", obs.size(), count);
    end
    start_session(32'h80);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({err_code, busy, in_ready, count} !== {2'b00, 2'b11, 16'd0}) begin
      errors++;
      $display("FAIL illegal_restart: err=%0d busy=%b in_ready=%b count=%0d, required 0 1 1 0", err_code, busy, in_ready, count);
    end
    drive_word(2, 0, 0, 0, 0, 1'b1, 1'b0, acc);
    wait_done(1'b0);
  endtask
  task automatic test_stall;
    bit acc;
    obs.delete();
    start_session(32'h200);
    drive_word(3, 4, 5, 6, 7, 1'b0, 1'b0, acc);
    @(negedge clk);
    mem_ready = 1'b0;
    in_valid = 1'b1;
    in_opc = 6'd4;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({mem_we, mem_addr, mem_wdata, in_ready, count} !== {1'b1, 32'h200, enc(3, 4, 5, 6, 7), 1'b0, 16'd0}) begin
        errors++;
        $display("FAIL stall_%0d: we=%b addr=%h data=%h in_ready=%b count=%0d, required 1 00000200 %h 0 0",
                 k, mem_we, mem_addr, mem_wdata, in_ready, count, enc(3, 4, 5, 6, 7));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    drive_word(4, 1, 1, 1, 1, 1'b1, 1'b0, acc);
    wait_done(1'b0);
    checks++;
    if (count !== 16'd2 || obs.size() != 2) begin
      errors++;
      $display("FAIL stall_release: count=%0d writes=%0d, required 2 2", count, obs.size());
    end
  endtask
  task automatic test_overflow;
    bit acc;
    obs.delete();
    start_session(32'h300);
    for (int i = 0; i < 4; i++) drive_word(i, 0, 0, 0, i, 1'b0, 1'b0, acc);
    drive_word(5, 0, 0, 0, 5, 1'b0, 1'b0, acc);
    @(negedge clk);
    checks++;
    if ({err_code, busy, mem_we, count} !== {2'd3, 2'b00, 16'd4} || obs.size() != 4) begin
      errors++;
      $display("FAIL overflow: err=%0d busy=%b we=%b count=%0d writes=%0d, required 3 0 0 4 4",
               err_code, busy, mem_we, count, obs.size());
    end
  endtask
  task automatic test_reset_mid;
    bit acc;
    obs.delete();
    start_session(32'h400);
    drive_word(2, 3, 4, 5, 6, 1'b0, 1'b0, acc);
    rst = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, mem_we, busy, done, err_code, count, mem_addr, mem_wdata} !== '0 || obs.size() != 0) begin
      errors++;
      $display("FAIL reset_mid: we=%b busy=%b count=%0d addr=%h data=%h writes=%0d, required all 0 and no write",
               mem_we, busy, count, mem_addr, mem_wdata, obs.size());
    end
    rst = 1'b0;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_random_sessions();
    test_stream();
    test_illegal(14, 0, 2'd1);
    test_illegal(13, 4, 2'd2);
    test_stall();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
